// File: rtl/conv_window_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_gen_if
//  Description : Row-in / window-out handshake bundle for conv_window_gen.
//                The master side feeds rows and consumes windows; the
//                slave side is the window generator itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface conv_window_gen_if #(
   parameter int BW      = 32,
   parameter int IM_SIZE = 32,
   parameter int K       = 3
);
   // Row input side
   logic                    row_valid;
   logic [BW*IM_SIZE-1:0]   row_in;
   logic                    row_ready;

   // Window output side
   logic                    win_valid;
   logic                    win_ready;
   logic [BW*K*K-1:0]       win_data;
   logic [4:0]              win_col;
   logic [4:0]              win_row;
   logic                    frame_done;

   modport master (
      output row_valid, row_in, win_ready,
      input  row_ready, win_valid, win_data, win_col, win_row, frame_done
   );

   modport slave (
      input  row_valid, row_in, win_ready,
      output row_ready, win_valid, win_data, win_col, win_row, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_gen
//  Description : Buffers the last K image rows and, once K rows of a frame
//                are present, emits IM_SIZE-K+1 KxK windows per new row,
//                one per cycle under a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_window_gen #(
   parameter int BW      = 32,
   parameter int IM_SIZE = 32,
   parameter int K       = 3
) (
   input  logic              clk,
   input  logic              rst,
   conv_window_gen_if.slave  bus
);

   localparam int              RL_W     = $clog2(K + 1);
   localparam logic [RL_W-1:0] RL_FULL  = RL_W'(K);
   localparam logic [RL_W-1:0] RL_PRIME = RL_W'(K - 1);
   localparam logic [4:0]      LAST_POS = 5'(IM_SIZE - K);

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [RL_W-1:0]        rows_loaded_q, rows_loaded_d;
   logic [4:0]             col_q, col_d;
   logic [4:0]             row_q, row_d;
   logic                   frame_done_q, frame_done_d;
   logic [BW*IM_SIZE-1:0]  rows_q [K];

   logic                   row_ready_w;
   logic                   win_valid_w;
   logic                   row_acc_w;
   logic                   win_acc_w;
   logic [BW*K*K-1:0]      win_data_w;

   // Handshake qualifiers; row_ready is held low during reset so no row is lost
   assign row_ready_w = (state_q == ST_FILL) && !rst;
   assign win_valid_w = (state_q == ST_SCAN);
   assign row_acc_w   = bus.row_valid && row_ready_w;
   assign win_acc_w   = win_valid_w && bus.win_ready;

   assign bus.row_ready  = row_ready_w;
   assign bus.win_valid  = win_valid_w;
   assign bus.win_data   = win_data_w;
   assign bus.win_col    = col_q;
   assign bus.win_row    = row_q;
   assign bus.frame_done = frame_done_q;

   // Window extraction: element (i,j) is word col+j of row register i
   always_comb begin
      win_data_w = '0;
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            win_data_w[(i*K + j)*BW +: BW] = rows_q[i][(int'(col_q) + j)*BW +: BW];
         end
      end
   end

   // Next-state logic for fill/scan sequencing and frame position counters
   always_comb begin
      state_d       = state_q;
      rows_loaded_d = rows_loaded_q;
      col_d         = col_q;
      row_d         = row_q;
      frame_done_d  = 1'b0;

      case (state_q)
         ST_FILL: begin
            if (row_acc_w) begin
               rows_loaded_d = (rows_loaded_q == RL_FULL) ? RL_FULL
                                                         : rows_loaded_q + 1'b1;
               // The row just accepted completes a K-row stack
               if (rows_loaded_q >= RL_PRIME) begin
                  state_d = ST_SCAN;
                  col_d   = '0;
               end
            end
         end

         ST_SCAN: begin
            if (win_acc_w) begin
               if (col_q < LAST_POS) begin
                  col_d = col_q + 1'b1;
               end else begin
                  col_d   = '0;
                  state_d = ST_FILL;
                  if (row_q == LAST_POS) begin
                     // Last window of the frame: next frame starts from empty
                     row_d         = '0;
                     rows_loaded_d = '0;
                     frame_done_d  = 1'b1;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end
            end
         end

         default: state_d = ST_FILL;
      endcase
   end

   // Control state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_FILL;
         rows_loaded_q <= '0;
         col_q         <= '0;
         row_q         <= '0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         rows_loaded_q <= rows_loaded_d;
         col_q         <= col_d;
         row_q         <= row_d;
         frame_done_q  <= frame_done_d;
      end
   end

   // Line buffer: oldest row drops out of R[0], new row enters R[K-1]
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < K; k++) begin
            rows_q[k] <= '0;
         end
      end else if (row_acc_w) begin
         for (int k = 0; k < K - 1; k++) begin
            rows_q[k] <= rows_q[k+1];
         end
         rows_q[K-1] <= bus.row_in;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_window_gen
//  Description : Self-checking bench for conv_window_gen: a row-history model
//                predicts every window, plus directed literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_window_gen;

   localparam int BW      = 32;
   localparam int IM_SIZE = 32;
   localparam int K       = 3;
   localparam int NWIN    = IM_SIZE - K + 1;
   localparam int DW      = BW * K * K;
   localparam int RW      = BW * IM_SIZE;

   typedef struct {
      logic [DW-1:0] data;
      int            col;
      int            row;
      bit            last;
   } win_t;

   logic clk;
   logic rst;

   conv_window_gen_if #(.BW(BW), .IM_SIZE(IM_SIZE), .K(K)) bus ();

   conv_window_gen #(.BW(BW), .IM_SIZE(IM_SIZE), .K(K)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model state
   win_t           exp_q[$];
   logic [RW-1:0]  hist[$];
   int             frame_rows = 0;
   bit             fd_pending = 0;
   int             win_cnt    = 0;
   int             fd_cnt     = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] mk_row(input int r);
      logic [RW-1:0] v;
      for (int w = 0; w < IM_SIZE; w++) v[w*BW +: BW] = BW'(r*100 + w);
      return v;
   endfunction

   function automatic logic [BW-1:0] elem(input logic [DW-1:0] d, input int e);
      return d[e*BW +: BW];
   endfunction

   // Model: a row enters the history; once K rows of the frame exist,
   // all windows over the newest K rows are queued for comparison.
   task automatic model_accept(input logic [RW-1:0] d);
      win_t          nw;
      logic [RW-1:0] tmp;
      hist.push_back(d);
      if (hist.size() > K) void'(hist.pop_front());
      frame_rows++;
      if (frame_rows >= K) begin
         for (int c = 0; c < NWIN; c++) begin
            nw.data = '0;
            for (int i = 0; i < K; i++) begin
               tmp = hist[i];
               for (int j = 0; j < K; j++) nw.data[(i*K + j)*BW +: BW] = tmp[(c + j)*BW +: BW];
            end
            nw.col  = c;
            nw.row  = frame_rows - K;
            nw.last = (frame_rows == IM_SIZE) && (c == NWIN - 1);
            exp_q.push_back(nw);
         end
      end
      if (frame_rows == IM_SIZE) begin
         hist.delete();
         frame_rows = 0;
      end
   endtask

   // Compare process: check outputs mid-cycle, then advance the model
   // for whatever the coming edge will do.
   always @(negedge clk) begin
      bit   ev, er;
      win_t cur;
      ev = (exp_q.size() != 0);
      er = !rst && !ev;
      chk("row_ready",  DW'(bus.row_ready),  DW'(er));
      chk("win_valid",  DW'(bus.win_valid),  DW'(ev));
      chk("frame_done", DW'(bus.frame_done), DW'(fd_pending));
      if (ev) begin
         cur = exp_q[0];
         chk("win_data", bus.win_data, cur.data);
         chk("win_col",  DW'(bus.win_col), DW'(cur.col));
         chk("win_row",  DW'(bus.win_row), DW'(cur.row));
      end
      if (bus.frame_done) fd_cnt++;

      fd_pending = 0;
      if (rst) begin
         exp_q.delete();
         hist.delete();
         frame_rows = 0;
      end else if (ev && bus.win_ready) begin
         cur = exp_q.pop_front();
         win_cnt++;
         if (cur.last) fd_pending = 1;
      end else if (er && bus.row_valid) begin
         model_accept(bus.row_in);
      end
   end

   // Present a row and hold it until the block takes it; returns just after
   // the accepting edge.
   task automatic send_row(input logic [RW-1:0] d);
      int n;
      bit ok;
      bus.row_valid = 1'b1;
      bus.row_in    = d;
      n  = 0;
      ok = 0;
      while (!ok && n < 2000) begin
         @(negedge clk);
         ok = bus.row_ready;
         n++;
      end
      chk("row_accept", DW'(ok), DW'(1));
      @(posedge clk); #1;
      bus.row_valid = 1'b0;
   endtask

   task automatic wait_col(input int c);
      int n;
      n = 0;
      while (!(bus.win_valid && int'(bus.win_col) == c) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reach_col", DW'(bus.win_col), DW'(c));
   endtask

   initial begin
      int base;
      int base3;
      int n;

      rst           = 1'b1;
      bus.row_valid = 1'b0;
      bus.row_in    = '0;
      bus.win_ready = 1'b1;

      // Reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_row_ready", DW'(bus.row_ready), DW'(1));
      chk("rst_win_valid", DW'(bus.win_valid), DW'(0));
      chk("rst_frame_done", DW'(bus.frame_done), DW'(0));
      chk("rst_win_data", bus.win_data, '0);
      chk("rst_win_col", DW'(bus.win_col), DW'(0));
      chk("rst_win_row", DW'(bus.win_row), DW'(0));
      @(posedge clk); #1;

      // Fill and scan
      base = win_cnt;
      send_row(mk_row(0));
      send_row(mk_row(1));
      send_row(mk_row(2));
      for (int c = 0; c < NWIN; c++) begin
         @(negedge clk);
         chk("scan_valid", DW'(bus.win_valid), DW'(1));
         chk("scan_col", DW'(bus.win_col), DW'(c));
         if (c == 0) begin
            chk("first_e0", DW'(elem(bus.win_data, 0)), DW'(0));
            chk("first_e4", DW'(elem(bus.win_data, 4)), DW'(101));
            chk("first_e8", DW'(elem(bus.win_data, 8)), DW'(202));
         end
         if (c == NWIN - 1) begin
            chk("last_e0", DW'(elem(bus.win_data, 0)), DW'(29));
            chk("last_e8", DW'(elem(bus.win_data, 8)), DW'(231));
         end
      end
      @(negedge clk);
      chk("after_row_ready", DW'(bus.row_ready), DW'(1));
      @(posedge clk); #1;

      // Backpressure at col 7 with a new row held during the scan
      base3 = win_cnt;
      send_row(mk_row(3));
      bus.row_valid = 1'b1;
      bus.row_in    = mk_row(4);
      wait_col(7);
      bus.win_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("bp_hold_col", DW'(bus.win_col), DW'(7));
      chk("bp_hold_valid", DW'(bus.win_valid), DW'(1));
      bus.win_ready = 1'b1;
      send_row(mk_row(4));
      chk("bp_row_windows", DW'(win_cnt - base3), DW'(NWIN));

      // Remainder of the frame
      for (int r = 5; r < IM_SIZE; r++) send_row(mk_row(r));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.frame_done && n < 100);
      chk("frame_done_seen", DW'(bus.frame_done), DW'(1));
      chk("fd_row_ready", DW'(bus.row_ready), DW'(1));
      chk("frame_windows", DW'(win_cnt - base), DW'(NWIN * (IM_SIZE - K + 1)));
      @(posedge clk); #1;

      // New frame needs K rows again
      base = win_cnt;
      send_row(mk_row(40));
      send_row(mk_row(41));
      repeat (40) @(negedge clk);
      chk("nf_no_windows", DW'(win_cnt - base), DW'(0));
      chk("fd_single", DW'(fd_cnt), DW'(1));
      @(posedge clk); #1;
      send_row(mk_row(42));
      @(negedge clk);
      chk("nf_valid", DW'(bus.win_valid), DW'(1));
      chk("nf_row", DW'(bus.win_row), DW'(0));
      chk("nf_e8", DW'(elem(bus.win_data, 8)), DW'(4202));
      @(posedge clk); #1;

      // Reset in the middle of a scan
      wait_col(15);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_valid", DW'(bus.win_valid), DW'(0));
      chk("mrst_ready", DW'(bus.row_ready), DW'(1));
      @(posedge clk); #1;
      send_row(mk_row(50));
      send_row(mk_row(51));
      repeat (10) @(negedge clk);
      chk("mrst_no_valid", DW'(bus.win_valid), DW'(0));
      @(posedge clk); #1;
      send_row(mk_row(52));
      @(negedge clk);
      chk("mrst_valid_back", DW'(bus.win_valid), DW'(1));
      chk("mrst_row", DW'(bus.win_row), DW'(0));
      chk("mrst_e0", DW'(elem(bus.win_data, 0)), DW'(5000));
      chk("mrst_e4", DW'(elem(bus.win_data, 4)), DW'(5101));

      // Drain
      n = 0;
      while (!bus.row_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_ready", DW'(bus.row_ready), DW'(1));
      chk("fd_total", DW'(fd_cnt), DW'(1));
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
